// File: rtl/evm_pkg.sv
// Shared types and helpers for the ballot sequencer: FSM state encoding and
// one-hot utilities used by the button qualifier.
package evm_pkg;

  localparam int N_CAND_DEF = 4;
  localparam int MAX_CAND   = 32;
  localparam int CIDX_W     = $clog2(MAX_CAND);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    QUALIFY,
    COMMIT,
    RELEASE,
    CLOSED
  } state_t;

  function automatic logic onehot_valid(input logic [MAX_CAND-1:0] v);
    return $countones(v) == 1;
  endfunction

  // Lowest set bit wins; only meaningful when onehot_valid() is true.
  function automatic logic [CIDX_W-1:0] onehot_index(input logic [MAX_CAND-1:0] v);
    logic [CIDX_W-1:0] r;
    r = '0;
    for (int i = MAX_CAND-1; i >= 0; i--)
      if (v[i]) r = CIDX_W'(i);
    return r;
  endfunction

endpackage

// File: rtl/button_qualifier.sv
// Single-button press qualifier: one-hot detect, index latch and hold counter.
// qualified means the press completes its hold requirement on this edge.
module button_qualifier
  import evm_pkg::*;
#(
  parameter int N_CAND      = N_CAND_DEF,
  parameter int HOLD_CYCLES = 4,
  localparam int IDX_W      = (N_CAND > 1) ? $clog2(N_CAND) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_CAND-1:0] button,
  input  logic              start,
  input  logic              track,
  output logic              single_hot,
  output logic              held,
  output logic [IDX_W-1:0]  index,
  output logic              qualified
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  cur_idx;
  logic [HOLD_W-1:0] hold_q;

  assign single_hot = onehot_valid(MAX_CAND'(button));
  assign cur_idx    = IDX_W'(onehot_index(MAX_CAND'(button)));
  assign held       = (button == (N_CAND'(1) << idx_q));
  assign index      = start ? cur_idx : idx_q;

  // With HOLD_CYCLES==1 the first sighting in ARMED already qualifies.
  assign qualified  = start ? (single_hot && (HOLD_CYCLES == 1))
                            : (track && held && ((32'(hold_q) + 1) >= HOLD_CYCLES));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      idx_q  <= '0;
    end else if (start && single_hot) begin
      hold_q <= HOLD_W'(1);
      idx_q  <= cur_idx;
    end else if (track && held) begin
      if (hold_q != HOLD_W'(HOLD_CYCLES)) hold_q <= hold_q + HOLD_W'(1);
    end else begin
      hold_q <= '0;
    end
  end

endmodule

// File: rtl/vote_controller.sv
// Ballot sequencer: arms one ballot per officer issue, qualifies a held single
// button press and emits one registered one-hot valid_vote pulse per ballot.
module vote_controller
  import evm_pkg::*;
#(
  parameter int N_CAND         = N_CAND_DEF,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int BALLOT_W       = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ballot_issue,
  input  logic [N_CAND-1:0]   button,
  input  logic                close_poll,
  output logic [N_CAND-1:0]   valid_vote,
  output logic                ready,
  output logic                ballot_void,
  output logic                poll_closed,
  output logic [BALLOT_W-1:0] ballots_cast
);

  localparam int IDX_W = (N_CAND > 1) ? $clog2(N_CAND) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state;
  logic [TO_W-1:0]  to_ctr;
  logic             bq_single, bq_held, bq_qual;
  logic [IDX_W-1:0] bq_index;
  logic             expire;

  button_qualifier #(
    .N_CAND      (N_CAND),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_bq (
    .clock      (clock),
    .reset      (reset),
    .button     (button),
    .start      (state == ARMED),
    .track      (state == QUALIFY),
    .single_hot (bq_single),
    .held       (bq_held),
    .index      (bq_index),
    .qualified  (bq_qual)
  );

  // This is the TIMEOUT_CYCLES-th armed cycle.
  assign expire = (to_ctr == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      to_ctr       <= '0;
      valid_vote   <= '0;
      ready        <= 1'b0;
      ballot_void  <= 1'b0;
      poll_closed  <= 1'b0;
      ballots_cast <= '0;
    end else begin
      valid_vote  <= '0;
      ballot_void <= 1'b0;
      case (state)
        IDLE: begin
          if (close_poll) begin
            state       <= CLOSED;
            poll_closed <= 1'b1;
          end else if (ballot_issue) begin
            state  <= ARMED;
            ready  <= 1'b1;
            to_ctr <= '0;
          end
        end
        ARMED, QUALIFY: begin
          // Closure beats a completing vote; a completing vote beats timeout.
          if (close_poll) begin
            state       <= CLOSED;
            ready       <= 1'b0;
            poll_closed <= 1'b1;
          end else if (bq_qual) begin
            state      <= COMMIT;
            ready      <= 1'b0;
            valid_vote <= N_CAND'(1) << bq_index;
            if (ballots_cast != '1) ballots_cast <= ballots_cast + BALLOT_W'(1);
          end else if (expire) begin
            state       <= IDLE;
            ready       <= 1'b0;
            ballot_void <= 1'b1;
          end else begin
            to_ctr <= to_ctr + TO_W'(1);
            if (state == ARMED && bq_single) state <= QUALIFY;
            else if (state == QUALIFY && !bq_held) state <= ARMED;
          end
        end
        COMMIT: state <= RELEASE;
        RELEASE: begin
          if (close_poll) begin
            state       <= CLOSED;
            poll_closed <= 1'b1;
          end else if (button == '0) begin
            state <= IDLE;
          end
        end
        CLOSED: state <= CLOSED;
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vote_controller.sv
// Directed plus randomized bench for vote_controller, checked each cycle
// against a ballot-level reference model.
module tb_vote_controller;

  localparam int N    = 4;
  localparam int HOLD = 4;
  localparam int TMO  = 1000;
  localparam int BW   = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ballot_issue = 1'b0;
  logic [N-1:0]  button = '0;
  logic          close_poll = 1'b0;
  logic [N-1:0]  valid_vote;
  logic          ready, ballot_void, poll_closed;
  logic [BW-1:0] ballots_cast;

  int checks = 0;
  int errors = 0;

  // Reference model: ballot open/closed, age, run of one held button.
  bit       m_open, m_closed, m_commit, m_wait;
  int       m_age, m_run, m_idx, m_cast;
  logic [N-1:0] e_vv;
  bit       e_void;

  vote_controller #(
    .N_CAND(N), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO), .BALLOT_W(BW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ballot_issue (ballot_issue),
    .button       (button),
    .close_poll   (close_poll),
    .valid_vote   (valid_vote),
    .ready        (ready),
    .ballot_void  (ballot_void),
    .poll_closed  (poll_closed),
    .ballots_cast (ballots_cast)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_closed = 0; m_commit = 0; m_wait = 0;
    m_age = 0; m_run = 0; m_idx = 0; m_cast = 0;
    e_vv = '0; e_void = 0;
  endtask

  task automatic model_step(input logic iss, input logic [N-1:0] b, input logic cl);
    e_vv = '0; e_void = 0;
    if (m_closed) begin
    end else if (m_commit) begin
      m_commit = 0; m_wait = 1;
    end else if (m_wait) begin
      if (cl) begin m_wait = 0; m_closed = 1; end
      else if (b == '0) m_wait = 0;
    end else if (m_open) begin
      if (cl) begin
        m_open = 0; m_closed = 1;
      end else begin
        if (m_run > 0) m_run = (b == (N'(1) << m_idx)) ? m_run + 1 : 0;
        else if ($countones(b) == 1) begin
          m_run = 1;
          for (int i = 0; i < N; i++) if (b[i]) m_idx = i;
        end
        m_age++;
        if (m_run == HOLD) begin
          e_vv = N'(1) << m_idx;
          if (m_cast < 255) m_cast++;
          m_open = 0; m_commit = 1; m_run = 0;
        end else if (m_age == TMO) begin
          e_void = 1; m_open = 0; m_run = 0;
        end
      end
    end else begin
      if (cl) m_closed = 1;
      else if (iss) begin m_open = 1; m_age = 0; m_run = 0; end
    end
  endtask

  task automatic tick(input logic iss, input logic [N-1:0] b, input logic cl);
    @(negedge clock);
    ballot_issue = iss; button = b; close_poll = cl;
    model_step(iss, b, cl);
    @(posedge clock); #1;
    chk("valid_vote",   32'(valid_vote),   32'(e_vv));
    chk("ready",        32'(ready),        32'(m_open));
    chk("ballot_void",  32'(ballot_void),  32'(e_void));
    chk("poll_closed",  32'(poll_closed),  32'(m_closed));
    chk("ballots_cast", 32'(ballots_cast), 32'(m_cast));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vv"},    32'(valid_vote),   0);
    chk({tag, "_rdy"},   32'(ready),        0);
    chk({tag, "_void"},  32'(ballot_void),  0);
    chk({tag, "_pc"},    32'(poll_closed),  0);
    chk({tag, "_cast"},  32'(ballots_cast), 0);
  endtask

  initial begin
    int lat, pulses, voids;
    logic [N-1:0] rb;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clock); reset = 1'b1;

    // 1: single press of candidate 2, latency and one-cycle pulse
    tick(1, 4'b0000, 0);
    lat = 0;
    for (int i = 0; i < 8 && lat == 0; i++) begin
      tick(0, 4'b0100, 0);
      if (valid_vote != '0) lat = i + 1;
    end
    chk("t1_latency", 32'(lat), HOLD);
    chk("t1_vote", 32'(valid_vote), 32'h4);
    tick(0, 4'b0000, 0);
    chk("t1_pulse_width", 32'(valid_vote), 0);
    chk("t1_cast", 32'(ballots_cast), 1);
    tick(0, 4'b0000, 0);

    // 2: multi-hot ignored, then single; short press then release -> ARMED
    tick(1, 4'b0000, 0);
    for (int i = 0; i < 10; i++) tick(0, 4'b0011, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick(0, 4'b0010, 0);
      if (valid_vote != '0) begin
        pulses++;
        chk("t2_vote", 32'(valid_vote), 32'h2);
      end
    end
    chk("t2_pulses", 32'(pulses), 1);
    tick(0, 4'b0000, 0);
    tick(1, 4'b0000, 0);
    for (int i = 0; i < 3; i++) tick(0, 4'b0001, 0);
    tick(0, 4'b0000, 0);
    chk("t2_still_ready", 32'(ready), 1);

    // 3: button held through commit and a new issue -> one vote only
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick((i == 7) ? 1'b1 : 1'b0, 4'b1000, 0);
      if (valid_vote != '0) pulses++;
    end
    chk("t3_pulses", 32'(pulses), 1);
    chk("t3_not_rearmed", 32'(ready), 0);
    tick(0, 4'b0000, 0);
    tick(1, 4'b0000, 0);
    for (int i = 0; i < 5; i++) tick(0, 4'b1000, 0);
    tick(0, 4'b0000, 0);
    tick(0, 4'b0000, 0);

    // 4: timeout with no press
    tick(1, 4'b0000, 0);
    lat = int'(ballots_cast);
    voids = 0;
    for (int i = 0; i < TMO + 2; i++) begin
      tick(0, 4'b0000, 0);
      if (ballot_void) voids++;
    end
    chk("t4_voids", 32'(voids), 1);
    chk("t4_cast_same", 32'(ballots_cast), 32'(lat));

    // random phase
    rb = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom % 4 == 0) begin
        case ($urandom % 4)
          0:       rb = '0;
          1, 2:    rb = N'(1) << ($urandom % N);
          default: rb = N'($urandom);
        endcase
      end
      tick(($urandom % 6) == 0, rb, 0);
    end
    for (int i = 0; i < 4; i++) tick(0, 4'b0000, 0);

    // 5: close in QUALIFY after two held cycles
    tick(1, 4'b0000, 0);
    tick(0, 4'b0100, 0);
    tick(0, 4'b0100, 0);
    lat = int'(ballots_cast);
    tick(0, 4'b0100, 1);
    chk("t5_closed", 32'(poll_closed), 1);
    for (int i = 0; i < 6; i++) tick(i == 1, 4'b0100, 0);
    chk("t5_cast_same", 32'(ballots_cast), 32'(lat));

    // 6: async reset mid-QUALIFY between edges, then saturation
    @(negedge clock); reset = 1'b0;
    #1; model_reset();
    @(negedge clock); reset = 1'b1;
    tick(1, 4'b0000, 0);
    tick(0, 4'b0001, 0);
    tick(0, 4'b0001, 0);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk_all_zero("t6_async");
    @(negedge clock); reset = 1'b1;
    for (int k = 0; k < 256; k++) begin
      tick(1, 4'b0000, 0);
      for (int i = 0; i < HOLD; i++) tick(0, N'(1) << (k % N), 0);
      tick(0, 4'b0000, 0);
      tick(0, 4'b0000, 0);
    end
    chk("t6_saturate", 32'(ballots_cast), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
